// File: rtl/cordic_vector.sv
// cordic_vector: iterative vectoring-mode CORDIC. Converts a Q3.14 (x, y)
// pair into a Q5.14 magnitude (CORDIC gain not compensated) and a Q3.14
// angle in radians. One micro-rotation per clock, fixed latency of ITER.
module cordic_vector #(
    parameter int ITER = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic signed [17:0] x_in,
    input  logic signed [17:0] y_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic signed [19:0] mag_out,
    output logic signed [17:0] angle_out
);

    typedef enum logic [1:0] {ST_IDLE, ST_ITER, ST_DONE} state_t;

    localparam logic [3:0]         LAST   = 4'(ITER - 1);
    localparam logic signed [17:0] PI_Q14 = 18'sd51472;

    state_t             state;
    state_t             state_nxt;
    logic signed [19:0] x;
    logic signed [19:0] y;
    logic signed [17:0] z;
    logic [3:0]         i;
    logic               accept;
    logic               done_ack;
    logic signed [19:0] x_ext;
    logic signed [19:0] y_ext;

    // atan(2^-idx) in Q3.14, rounded to nearest.
    function automatic logic signed [17:0] atan_lut(input logic [3:0] idx);
        case (idx)
            4'd0:    return 18'sd12868;
            4'd1:    return 18'sd7596;
            4'd2:    return 18'sd4014;
            4'd3:    return 18'sd2037;
            4'd4:    return 18'sd1023;
            4'd5:    return 18'sd512;
            4'd6:    return 18'sd256;
            4'd7:    return 18'sd128;
            4'd8:    return 18'sd64;
            4'd9:    return 18'sd32;
            4'd10:   return 18'sd16;
            4'd11:   return 18'sd8;
            4'd12:   return 18'sd4;
            4'd13:   return 18'sd2;
            4'd14:   return 18'sd1;
            default: return 18'sd0;
        endcase
    endfunction

    // Handshakes: ready is held low while reset is asserted.
    assign in_ready  = (state == ST_IDLE) && !rst;
    assign out_valid = (state == ST_DONE);
    assign accept    = in_valid && in_ready;
    assign done_ack  = out_valid && out_ready;
    assign x_ext     = {{2{x_in[17]}}, x_in};
    assign y_ext     = {{2{y_in[17]}}, y_in};
    assign mag_out   = x;
    assign angle_out = z;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        // NOTE: default first so no path leaves state_nxt unassigned (no latch).
        state_nxt = state;
        unique case (state)
            ST_IDLE: if (accept)       state_nxt = ST_ITER;
            ST_ITER: if (i == LAST)    state_nxt = ST_DONE;
            ST_DONE: if (done_ack)     state_nxt = ST_IDLE;
            default:                   state_nxt = ST_IDLE;
        endcase
    end

    // Datapath: pre-rotation on capture, then one micro-rotation per cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x <= '0;
            y <= '0;
            z <= '0;
            i <= '0;
        end else if (accept) begin
            i <= '0;
            if (!x_in[17]) begin
                x <= x_ext;
                y <= y_ext;
                z <= '0;
            end else begin
                // Left half-plane: rotate by pi so the iterations converge.
                x <= -x_ext;
                y <= -y_ext;
                z <= y_in[17] ? -PI_Q14 : PI_Q14;
            end
        end else if (state == ST_ITER) begin
            // NOTE: non-blocking updates make both right-hand sides read the
            // pre-update x and y, which the cross-coupled rotation requires.
            if (!y[19]) begin
                x <= x + (y >>> i);
                y <= y - (x >>> i);
                z <= z + atan_lut(i);
            end else begin
                x <= x - (y >>> i);
                y <= y + (x >>> i);
                z <= z - atan_lut(i);
            end
            i <= i + 4'd1;
        end
    end

endmodule
